// File: rtl/io_pad_pkg.sv
// io_pad_pkg: shared drive-mode type and default sizing for the pad bank.
package io_pad_pkg;
  typedef enum logic {
    IO_PUSH_PULL  = 1'b0,
    IO_OPEN_DRAIN = 1'b1
  } io_mode_t;
  localparam int N_PINS_DEF      = 24;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_W_DEF    = 4;
endpackage

// File: rtl/io_pad_if.sv
// io_pad_if: core-side and pad-side signals of the pad bank.
interface io_pad_if
  import io_pad_pkg::*;
#(
  parameter int N_PINS   = N_PINS_DEF,
  parameter int FILTER_W = FILTER_W_DEF
);
  logic [N_PINS-1:0]   core_o;
  logic [N_PINS-1:0]   core_oe;
  logic [N_PINS-1:0]   mode_od;
  logic [N_PINS-1:0]   filt_en;
  logic [FILTER_W-1:0] filt_thresh;
  logic [N_PINS-1:0]   pad_i;
  logic [N_PINS-1:0]   pad_o;
  logic [N_PINS-1:0]   pad_oe;
  logic [N_PINS-1:0]   core_i;
  logic [N_PINS-1:0]   rise_o;
  logic [N_PINS-1:0]   fall_o;
  logic [N_PINS-1:0]   snoop_o;
  modport master (
    output core_o, core_oe, mode_od, filt_en, filt_thresh, pad_i,
    input  pad_o, pad_oe, core_i, rise_o, fall_o, snoop_o
  );
  modport slave (
    input  core_o, core_oe, mode_od, filt_en, filt_thresh, pad_i,
    output pad_o, pad_oe, core_i, rise_o, fall_o, snoop_o
  );
endinterface

// File: rtl/io_pad_filter.sv
// io_pad_filter: one pin's input synchroniser, glitch filter, edge pulses and snoop mux.
module io_pad_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_W    = 4,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pad_i,
  input  logic                filt_en,
  input  logic [FILTER_W-1:0] filt_thresh,
  input  logic                pad_o,
  input  logic                pad_oe,
  output logic                core_i,
  output logic                rise_o,
  output logic                fall_o,
  output logic                snoop_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILTER_W-1:0]    cnt, cnt_d;
  logic                   sync, stable, stable_d, diff, take;
  assign sync = sync_q[SYNC_STAGES-1];
  always_comb begin
    diff     = sync != stable;
    take     = !filt_en || (diff && cnt >= filt_thresh);
    stable_d = take ? sync : stable;
    cnt_d    = (!filt_en || !diff || take) ? '0 : cnt + 1'b1;
  end
  // Edge pulses compare the next stable value so they line up with core_i.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      stable <= RST_VAL;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      stable <= stable_d;
      cnt    <= cnt_d;
      rise_o <= stable_d & ~stable;
      fall_o <= ~stable_d & stable;
    end
  assign core_i  = stable;
  assign snoop_o = pad_oe ? pad_o : sync;
endmodule

// File: rtl/io_pad_bank.sv
// io_pad_bank: N bidirectional pad channels with registered drive and filtered readback.
module io_pad_bank
  import io_pad_pkg::*;
#(
  parameter int                N_PINS      = N_PINS_DEF,
  parameter int                SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int                FILTER_W    = FILTER_W_DEF,
  parameter logic [N_PINS-1:0] PIN_RST_VAL = '1
) (
  input logic     clk,
  input logic     rst,
  io_pad_if.slave io
);
  logic [N_PINS-1:0] pad_o_d, pad_oe_d, core_i, rise, fall, snoop;
  // Open-drain only ever pulls low: enable follows the inverted data.
  always_comb begin
    pad_o_d  = '0;
    pad_oe_d = '0;
    for (int i = 0; i < N_PINS; i++) begin
      pad_o_d[i]  = io_mode_t'(io.mode_od[i]) == IO_OPEN_DRAIN ? 1'b0 : io.core_o[i];
      pad_oe_d[i] = io_mode_t'(io.mode_od[i]) == IO_OPEN_DRAIN ? ~io.core_o[i] : io.core_oe[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      io.pad_o  <= '0;
      io.pad_oe <= '0;
    end else begin
      io.pad_o  <= pad_o_d;
      io.pad_oe <= pad_oe_d;
    end
  for (genvar g = 0; g < N_PINS; g++) begin : g_pin
    io_pad_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_W   (FILTER_W),
      .RST_VAL    (PIN_RST_VAL[g])
    ) u_filt (
      .clk        (clk),
      .rst        (rst),
      .pad_i      (io.pad_i[g]),
      .filt_en    (io.filt_en[g]),
      .filt_thresh(io.filt_thresh),
      .pad_o      (io.pad_o[g]),
      .pad_oe     (io.pad_oe[g]),
      .core_i     (core_i[g]),
      .rise_o     (rise[g]),
      .fall_o     (fall[g]),
      .snoop_o    (snoop[g])
    );
  end
  assign io.core_i  = core_i;
  assign io.rise_o  = rise;
  assign io.fall_o  = fall;
  assign io.snoop_o = snoop;
endmodule

// File: tb/tb_io_pad_bank.sv
// tb_io_pad_bank: directed checks of drive modes, sync latency, glitch filter and reset.
module tb_io_pad_bank;
  localparam logic [23:0] ALL = 24'hFF_FFFF;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  io_pad_if #(.N_PINS(24), .FILTER_W(4)) io ();
  io_pad_bank dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    io.core_o = '0;
    io.core_oe = ALL;
    io.mode_od = '0;
    io.filt_en = '0;
    io.filt_thresh = '0;
    io.pad_i = ALL;
    #12;
    check("rst_pad_oe", io.pad_oe, 0);
    check("rst_pad_o", io.pad_o, 0);
    check("rst_core_i", io.core_i, ALL);
    check("rst_rise", io.rise_o, 0);
    check("rst_fall", io.fall_o, 0);
    check("rst_snoop", io.snoop_o, ALL);
    io.core_oe = '0;
    io.pad_i = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);
    check("rel_no_fall_c2", io.fall_o, 0);
    check("rel_core_i_c2", io.core_i, ALL);
    tick(1);
    check("rel_fall_c3", io.fall_o, ALL);
    check("rel_core_i_c3", io.core_i, 0);
    tick(1);
    check("rel_fall_one", io.fall_o, 0);
    io.core_oe = 24'h20;
    io.core_o = 24'h20;
    tick(1);
    check("pp_pad_oe", io.pad_oe, 24'h20);
    check("pp_pad_o", io.pad_o, 24'h20);
    check("pp_snoop", io.snoop_o, 24'h20);
    io.pad_i = 24'h20;
    tick(2);
    check("pp_core_i_c2", io.core_i, 0);
    tick(1);
    check("pp_core_i_c3", io.core_i, 24'h20);
    check("pp_rise", io.rise_o, 24'h20);
    tick(1);
    check("pp_rise_one", io.rise_o, 0);
    io.core_oe = '0;
    io.core_o = '0;
    io.mode_od = 24'h1;
    io.pad_i = 24'h1;
    tick(4);
    check("od_settle", io.core_i, 24'h1);
    io.core_o = 24'h1;
    io.core_oe = 24'h1;
    tick(1);
    check("od_hi_oe", io.pad_oe, 0);
    check("od_hi_o", io.pad_o, 0);
    io.core_o = 24'h0;
    tick(1);
    check("od_lo_oe", io.pad_oe, 24'h1);
    check("od_lo_o", io.pad_o, 0);
    check("od_lo_snoop", io.snoop_o[0], 0);
    io.core_o = 24'h1;
    io.pad_i = 24'h0;
    tick(1);
    check("od_rel_oe", io.pad_oe, 0);
    check("od_stretch_c1", io.core_i[0], 1);
    tick(1);
    check("od_stretch_c2", io.core_i[0], 1);
    tick(1);
    check("od_stretch_c3", io.core_i[0], 0);
    check("od_stretch_fall", io.fall_o, 24'h1);
    check("od_stretch_snoop", io.snoop_o[0], 0);
    io.mode_od = '0;
    io.core_oe = '0;
    io.core_o = '0;
    io.filt_en = ALL;
    io.filt_thresh = 4'd3;
    io.pad_i = ALL;
    tick(5);
    check("flt_rise_c5", io.core_i, 0);
    tick(1);
    check("flt_rise_c6", io.core_i, ALL);
    check("flt_rise_pulse", io.rise_o, ALL);
    tick(2);
    io.pad_i = '0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 3) io.pad_i = ALL;
      check("glitch3_core_i", io.core_i, ALL);
      check("glitch3_fall", io.fall_o, 0);
    end
    io.pad_i = '0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 4) io.pad_i = ALL;
      check("glitch4_core_i", io.core_i, k >= 6 ? 0 : ALL);
      check("glitch4_fall", io.fall_o, k == 6 ? ALL : 0);
    end
    tick(4);
    check("thr_settle", io.core_i, ALL);
    io.filt_thresh = 4'd10;
    io.pad_i = '0;
    tick(7);
    check("thr_hold", io.core_i, ALL);
    io.filt_thresh = 4'd2;
    tick(1);
    check("thr_lowered", io.core_i, 0);
    check("thr_fall", io.fall_o, ALL);
    io.filt_thresh = 4'd3;
    io.core_oe = ALL;
    io.core_o = 24'h0F0F0F;
    io.pad_i = ALL;
    tick(4);
    check("mid_pre_oe", io.pad_oe, ALL);
    check("mid_pre_core_i", io.core_i, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_oe", io.pad_oe, 0);
    check("mid_rst_o", io.pad_o, 0);
    check("mid_rst_core_i", io.core_i, ALL);
    check("mid_rst_snoop", io.snoop_o, ALL);
    check("mid_rst_rise", io.rise_o, 0);
    check("mid_rst_fall", io.fall_o, 0);
    io.core_oe = '0;
    io.pad_i = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(5);
    check("mid_rel_c5", io.core_i, ALL);
    tick(1);
    check("mid_rel_c6", io.core_i, 0);
    check("mid_rel_fall", io.fall_o, ALL);
    io.filt_en = '0;
    for (int k = 1; k <= 8; k++) begin
      io.pad_i = (k % 2 == 1) ? ALL : 24'h0;
      tick(1);
      if (k >= 3) begin
        check("b2b_rise", io.rise_o, ((k - 2) % 2 == 1) ? ALL : 0);
        check("b2b_fall", io.fall_o, ((k - 2) % 2 == 0) ? ALL : 0);
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/io_pad_bank.md
# io_pad_bank

Parametrised bank of N bidirectional pad channels between the SoC core and the top-level tristate buffers. Generalises the per-port GPIO, USB and I2C (de)muxing into one block. Each pin has a selectable push-pull or open-drain drive mode, a multi-stage input synchroniser, an optional programmable glitch filter, edge-detect pulses and a snoop output. The block sits in the top level, directly behind the pad tristates; the top level only instantiates `pad = pad_oe ? pad_o : 'Z`.

## Interface
Parameters:
- `N_PINS`, 24: number of pad channels.
- `SYNC_STAGES`, 2: input synchroniser depth, minimum 2.
- `FILTER_W`, 4: glitch-filter counter width.
- `PIN_RST_VAL`, all ones: per-pin reset value of the synchroniser and filtered state (idle-high buses).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `core_o`, in, N_PINS: value the core drives.
- `core_oe`, in, N_PINS: core output enable (push-pull mode only).
- `mode_od`, in, N_PINS: 1 = open-drain, 0 = push-pull.
- `filt_en`, in, N_PINS: per-pin glitch filter enable.
- `filt_thresh`, in, FILTER_W: common filter threshold.
- `pad_i`, in, N_PINS: raw pad input (asynchronous).
- `pad_o`, out, N_PINS: registered pad drive value.
- `pad_oe`, out, N_PINS: registered pad drive enable.
- `core_i`, out, N_PINS: synchronised, filtered pad value.
- `rise_o`, out, N_PINS: one-cycle pulse on a 0→1 transition of `core_i`.
- `fall_o`, out, N_PINS: one-cycle pulse on a 1→0 transition of `core_i`.
- `snoop_o`, out, N_PINS: observed line value, for debug pins.

## Operation
- **Output path, registered each cycle:**
  - Push-pull: `pad_oe <= core_oe`, `pad_o <= core_o`.
  - Open-drain: `pad_oe <= ~core_o`, `pad_o <= 0`. The block never drives high.
- **Input path:** `pad_i` passes through a `SYNC_STAGES` flop chain to produce `sync`. `core_i` reflects the real line, including while the pin is driving (readback).
- **Filter per pin:** state `stable` and counter `cnt` (FILTER_W bits).
  - `filt_en=0`: `stable <= sync`, `cnt <= 0`.
  - `filt_en=1`, `sync == stable`: `cnt <= 0`.
  - `filt_en=1`, `sync != stable`, `cnt >= filt_thresh`: `stable <= sync`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - `cnt` never wraps, because `>=` catches it before overflow. A threshold lowered mid-count takes effect on the next differing cycle.
- **Outputs from filter state:**
  - `core_i = stable`.
  - `rise_o` and `fall_o` are registered. They assert in the same cycle that `core_i` first shows the new value, for exactly one cycle.
- **Snoop:** `snoop_o = pad_oe ? pad_o : sync` (combinational from registers; unfiltered).
- **Mode or enable changes:** take effect on the next clock. No internal state is cleared.
- **Reset, asynchronous, any time including mid-filter count:**
  - `pad_oe = 0` and `pad_o = 0`: all pins tristate.
  - Sync chain and `stable` = `PIN_RST_VAL`, `cnt = 0`.
  - `rise_o = fall_o = 0`.
  - `core_i = snoop_o = PIN_RST_VAL`.
  - No edge pulse is generated on reset release, even if `pad_i` differs. The first edge appears after normal latency.

## Timing
- **Output latency:** 1 cycle from `core_o`/`core_oe`/`mode_od` to `pad_o`/`pad_oe`.
- **Input latency, filter off or `filt_thresh=0`:** `SYNC_STAGES + 1` cycles from the first sampling edge seeing the new `pad_i` to `core_i` changing, with the edge pulse in that same cycle.
- **Filter on:** `sync` must differ from `stable` for `filt_thresh + 1` consecutive cycles.
  - Total latency is `SYNC_STAGES + filt_thresh + 1`.
  - A pulse of up to `filt_thresh` cycles on `sync` is fully rejected.
- **Back-to-back toggles:** filter off, `sync` toggling every cycle yields alternating `rise_o`/`fall_o` on consecutive cycles. No pulse is merged.

## Structure
- **Package `io_pad_pkg`:** `io_mode_t` enum (`IO_PUSH_PULL`, `IO_OPEN_DRAIN`) and the default parameter constants.
- **Sub-module `io_pad_filter`:** one pin's sync chain, filter counter, edge register and snoop mux.
- **Bank:** instantiates `io_pad_filter` N_PINS times in a generate loop; the output registers live in the bank.

## Test plan
- **Reset tristate:** assert `rst` with `core_oe` all ones. Expect `pad_oe=0`, `core_i=0xFFFFFF`, no `rise_o`/`fall_o`. After release with `pad_i=0`, expect `fall_o` on all pins at cycle 3.
- **Push-pull:** pin 5, `core_oe=1`, `core_o=1`. Expect `pad_oe[5]=1`, `pad_o[5]=1` one cycle later; loop `pad_i[5]=pad_o[5]` and expect `core_i[5]=1`, `snoop_o[5]=1`.
- **Open-drain (I2C-style):** pin 0, `core_o` 1→0. Expect `pad_oe[0]` 0→1 with `pad_o[0]=0`. With `core_o=1` and `pad_i[0]=0` (external stretch), expect `core_i[0]=0` after 3 cycles.
- **Glitch reject:** `filt_en=1`, `filt_thresh=3`. A 3-cycle low pulse on `pad_i` gives no change. A 4-cycle low gives `core_i` falling at cycle 6 with a single `fall_o`.
- **Threshold change mid-count:** `filt_thresh` 10→2 while `cnt=5` and still differing. Expect `stable` to update on the next cycle.
- **Reset mid-operation:** `rst` asserted during a filter count. Expect outputs to return to their reset values immediately and `cnt=0` after release.
